// File: rtl/distributor_2bits.sv
// distributor_2bits: registered 1-to-4 distributor.
// One WIDTH-bit word per input handshake is steered into one of four
// one-entry output holding registers, each with its own valid/ready pair.
//
// Optional feature macro: SELECT_AUTO_EN
//   undefined (default): destination channel = select.
//   defined:             select is ignored; destination comes from an internal
//                        2-bit round-robin pointer that advances after every accept.
//
// Handshake semantics (all channels, input and outputs):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Valid never depends combinationally on ready. The producer holds
//   number_in and select stable while in_valid is high and in_ready is low.
//   in_ready depends only on select/pointer, out_valid and out_ready, never
//   on number_in or in_valid.
module distributor_2bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] number_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] number1,
    output logic [WIDTH-1:0] number2,
    output logic [WIDTH-1:0] number3,
    output logic [WIDTH-1:0] number4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
);

    // Per-channel holding registers and their valid bits.
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       valid_q;

    // Destination channel of the word currently offered.
    logic [1:0] dest;
    logic       accept;
    logic [3:0] load;

`ifdef SELECT_AUTO_EN
    logic [1:0] ptr_q;
    logic       unused_select;

    // select has no role when the pointer chooses the destination.
    assign unused_select = ^select;

    // Round-robin pointer: advances by one after every accepted word, wraps 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'b00;
        end else if (accept) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end

    assign dest = ptr_q;
`else
    assign dest = select;
`endif

    // Destination can take a word if it is empty or is being drained this cycle.
    always_comb begin
        in_ready = ~valid_q[dest] | out_ready[dest];
    end

    assign accept = in_valid & in_ready;

    // One-hot load strobe for the destination channel on an accept.
    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[dest] = 1'b1;
        end
    end

    // Valid bits: a load wins over a drain on the same channel, so
    // simultaneous drain+accept keeps the channel valid with the new word.
    // out_ready on an empty channel clears an already-clear bit: no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
        end else begin
            valid_q <= load | (valid_q & ~out_ready);
        end
    end

    // Data registers: written only on a load; a drain leaves the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= number_in;
                end
            end
        end
    end

    assign number1   = data_q[0];
    assign number2   = data_q[1];
    assign number3   = data_q[2];
    assign number4   = data_q[3];
    assign out_valid = valid_q;

endmodule

// File: doc/distributor_2bits.md
Name: distributor_2bits

Overview:
- Registered 1-to-4 distributor: the inverse of the 2-bit-select 4:1 selector.
- Accepts one WIDTH-bit word per handshake on a single input and steers it to one of four output channels chosen by a 2-bit select.
- Each output channel has a one-entry holding register with its own valid/ready handshake.
- Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 8, data width of the input word and of each output channel.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- number_in  input  WIDTH  input data word
- in_valid  input  1  producer presents a valid word
- in_ready  output  1  distributor can accept the word this cycle
- select  input  2  destination: 2'b00 to channel1, 2'b01 to channel2, 2'b10 to channel3, 2'b11 to channel4; sampled only when in_valid is high
- number1, number2, number3, number4  output  WIDTH each  channel holding registers
- out_valid  output  4  bit k-1 set means channel k holds a valid word
- out_ready  input  4  bit k-1 set means consumer k takes its word this cycle

Behaviour:
- Reset: clk single domain; rst_n asynchronous assert, synchronous deassert. While asserted: number1..4 = 0, out_valid = 4'b0000, internal state cleared. in_ready is combinational and therefore high after reset.
- Destination d: select in normal build; auto pointer when SELECT_AUTO_EN is defined.
- Channel state: per channel k, a data register plus valid bit vk.
- in_ready = ~vd | out_ready[d]. It is combinational from select, out_valid and out_ready; no combinational path from number_in.
- Accept: in_valid & in_ready. On the next edge, channel d loads number_in and vd = 1. Latency is 1 cycle from accept to out_valid.
- Drain: vk & out_ready[k] with no accept to k on the same edge. On that edge vk = 0 and the data register holds its old value (no clear).
- Simultaneous drain and accept on the same channel: the new word replaces the old, vk stays 1. Throughput on one channel is 1 word per cycle.
- Accepts and drains on different channels are independent on the same edge.
- Full channel (vd = 1, out_ready[d] = 0): in_ready = 0. The producer must hold number_in and select stable until accepted. Other channels keep draining.
- out_ready to an empty channel (vk = 0) has no effect.
- in_valid = 0: select is ignored and no state changes except drains.
- No reordering within a channel. No ordering guarantee across channels.
- Reset mid-operation: any held words are discarded and all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: SELECT_AUTO_EN.
- When defined:
  - The select port is ignored.
  - d comes from an internal 2-bit pointer, reset to 2'b00.
  - The pointer increments by 1 after each accept and wraps 2'b11 to 2'b00.
  - in_ready uses the pointer's channel, so a stalled channel blocks the input even when other channels are empty.
- When not defined: no pointer register exists and d = select.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary inputs -> out_valid = 0000, number1..4 = 0, in_ready = 1. Release, then assert rst_n = 0 asynchronously mid-cycle while channel2 is valid -> out_valid drops to 0000 before the next edge.
- Routing: out_ready = 0000; send 8'h11/sel 00, 8'h22/01, 8'h33/10, 8'h44/11 on consecutive cycles -> number1..4 = 11/22/33/44, out_valid = 1111 one cycle after each accept. A fifth word with sel 01 -> in_ready = 0 and the word is held.
- Back-pressure and simultaneous events: channel3 holds 8'hA5 with out_ready[2] = 0; offer 8'h5A/sel 10 -> in_ready = 0 for 3 cycles. Raise out_ready[2] -> in_ready = 1 that cycle; next edge number3 = 5A, out_valid[2] stays 1.
- Streaming: out_ready = 1111, sel = 00, in_valid high for 16 cycles with data 0..15 -> in_ready constantly 1, number1 follows data with 1-cycle latency, out_valid[0] drops the cycle after in_valid falls.
- Independence: channel1 stalled full with out_ready[0] = 0; traffic to channel4 with out_ready[3] = 1 -> channel4 passes 1 word per cycle, channel1 value unchanged.
- SELECT_AUTO_EN build: out_ready = 1111, select tied to 2'b11, send 8'h01..8'h06 -> words land in channels 1, 2, 3, 4, 1, 2 (pointer wraps). With channel2 full, out_ready[1] = 0 and the pointer at 01 -> in_ready = 0 although channels 1, 3 and 4 are empty.
